// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with single-entry holding register
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 200,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data_byte,
  output logic                 o_data_avail,
  input  logic                 i_data_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int BIT_MAX  = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BIT_W    = $clog2(BIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_e;

  // line synchronizer and edge detector
  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;
  logic rx_fall;

  // receive engine
  state_e               state_q,    state_d;
  logic [CNT_W-1:0]     cyc_q,      cyc_d;
  logic [BIT_W-1:0]     bit_q,      bit_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 par_bit_q,  par_bit_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 bit_sample;
  logic                 complete;
  logic                 done_ferr;
  logic                 done_perr;
  logic                 par_xor;

  // holding register
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 avail_q,     avail_d;
  logic                 perr_q,      perr_d;
  logic                 ferr_q,      ferr_d;
  logic                 ovr_q,       ovr_d;
  logic                 consume;

  // Two-flop synchronizer idles high; the edge detector starts disarmed so a
  // line that is already low when reset releases is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall    = rx_prev_q & ~rx_sync_q;
  assign bit_sample = (cyc_q == CNT_W'(CLKS_PER_BIT - 1));

  // Receive state register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      ferr_acc_q <= ferr_acc_d;
    end
  end

  // Frame sequencing: the start bit is confirmed at mid-bit, every later bit
  // is sampled a full bit period after the previous sample.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    ferr_acc_d = ferr_acc_q;
    complete   = 1'b0;
    done_ferr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          state_d    = S_START;
          cyc_d      = '0;
          bit_d      = '0;
          ferr_acc_d = 1'b0;
        end
      end
      S_START: begin
        if (cyc_q == CNT_W'(HALF_BIT)) begin
          cyc_d   = '0;
          // a high line here means the falling edge was a glitch
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_sample) begin
          cyc_d   = '0;
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_sample) begin
          cyc_d     = '0;
          par_bit_d = rx_sync_q;
          state_d   = S_STOP;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_sample) begin
          cyc_d = '0;
          if (!rx_sync_q) begin
            ferr_acc_d = 1'b1;
          end
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            complete  = 1'b1;
            done_ferr = ferr_acc_q | ~rx_sync_q;
            bit_d     = '0;
            state_d   = done_ferr ? S_BREAK_WAIT : S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_BREAK_WAIT: begin
        // a held-low line (break) must return high before a new frame can start
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Parity verdict for the frame in the shift register.
  always_comb begin
    par_xor   = (^shift_q) ^ par_bit_q;
    done_perr = 1'b0;
    if (PARITY_MODE == 2) begin
      done_perr = par_xor;
    end else if (PARITY_MODE == 1) begin
      done_perr = ~par_xor;
    end
  end

  assign consume = avail_q & i_data_ready;

  // Holding register: a completed frame loads only if the slot is free or
  // being consumed this cycle; otherwise it is dropped and flagged as overrun.
  always_comb begin
    hold_data_d = hold_data_q;
    avail_d     = avail_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    ovr_d       = ovr_q;
    if (consume) begin
      avail_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (complete) begin
      if (!avail_q || consume) begin
        hold_data_d = shift_q;
        perr_d      = done_perr;
        ferr_d      = done_ferr;
        avail_d     = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q <= '0;
      avail_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      avail_q     <= avail_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign o_data_byte  = hold_data_q;
  assign o_data_avail = avail_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed bench for uart_rx_cfg (8N1 default and 8E1 instances)
module tb_uart_rx_cfg;

  localparam int CPB0 = 200;
  localparam int CPB1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx0, rx1, rdy0, rdy1;
  logic [7:0] data0, data1;
  logic       avail0, perr0, ferr0, ovr0, busy0;
  logic       avail1, perr1, ferr1, ovr1, busy1;

  int n_vec = 0;
  int n_bad = 0;
  int pulses0 = 0;
  logic [7:0] cap0 = 8'h00;
  logic       capp0 = 1'b0;
  logic       capf0 = 1'b0;

  uart_rx_cfg u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_rx(rx0),
    .o_data_byte(data0), .o_data_avail(avail0), .i_data_ready(rdy0),
    .o_parity_err(perr0), .o_frame_err(ferr0), .o_overrun(ovr0), .o_busy(busy0)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB1), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_rx(rx1),
    .o_data_byte(data1), .o_data_avail(avail1), .i_data_ready(rdy1),
    .o_parity_err(perr1), .o_frame_err(ferr1), .o_overrun(ovr1), .o_busy(busy1)
  );

  // count cycles with data available on dut0 and remember what was shown
  always @(negedge clk) begin
    if (avail0) begin
      pulses0 = pulses0 + 1;
      cap0    = data0;
      capp0   = perr0;
      capf0   = ferr0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input int sel, input logic v, input int cycles);
    if (sel == 0) rx0 = v; else rx1 = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input logic use_par,
                            input logic par, input logic stop_v);
    int cpb;
    cpb = (sel == 0) ? CPB0 : CPB1;
    drive_bit(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(sel, data[i], cpb);
    if (use_par) drive_bit(sel, par, cpb);
    drive_bit(sel, stop_v, cpb);
  endtask

  task automatic consume(input int sel);
    if (sel == 0) rdy0 = 1'b1; else rdy1 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    rdy1 = 1'b0;
  endtask

  initial begin
    int p;
    logic [7:0] pat;
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_avail",  avail0, 1'b0);
    check("rst_data",   data0,  8'h00);
    check("rst_flags",  {perr0, ferr0, ovr0}, 3'b000);
    check("rst_busy",   busy0,  1'b0);
    check("rst_dut1",   {avail1, busy1, perr1, ferr1, ovr1}, 5'b00000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0x55 8N1 with consumer always ready
    rdy0 = 1'b1;
    p = pulses0;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("t1_pulses", pulses0 - p, 1);
    check("t1_data",   cap0, 8'h55);
    check("t1_flags",  {capp0, capf0}, 2'b00);
    check("t1_avail",  avail0, 1'b0);
    check("t1_busy",   busy0, 1'b0);
    rdy0 = 1'b0;

    // even parity: 0xA5 has four ones, so parity bit 1 is wrong, 0 is right
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("t2a_avail", avail1, 1'b1);
    check("t2a_data",  data1, 8'hA5);
    check("t2a_perr",  perr1, 1'b1);
    check("t2a_ferr",  ferr1, 1'b0);
    consume(1);
    check("t2a_taken", avail1, 1'b0);
    send_frame(1, 8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t2b_avail", avail1, 1'b1);
    check("t2b_data",  data1, 8'hA5);
    check("t2b_perr",  perr1, 1'b0);
    consume(1);

    // glitch of a quarter bit is rejected at the mid-start resample
    rx0 = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_busy_in", busy0, 1'b1);
    repeat (CPB0 / 4 - 10) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * CPB0) @(negedge clk);
    check("t3_busy",  busy0, 1'b0);
    check("t3_avail", avail0, 1'b0);
    check("t3_flags", {perr0, ferr0, ovr0}, 3'b000);

    // 0x3C with stop bit low and line held low: frame error, break wait
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 2 * CPB0);
    check("t4_avail", avail0, 1'b1);
    check("t4_data",  data0, 8'h3C);
    check("t4_ferr",  ferr0, 1'b1);
    check("t4_perr",  perr0, 1'b0);
    check("t4_busy",  busy0, 1'b1);
    drive_bit(0, 1'b1, CPB0);
    check("t4_idle",  busy0, 1'b0);
    consume(0);
    check("t4_taken", avail0, 1'b0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t4_next_data",  data0, 8'h81);
    check("t4_next_flags", {avail0, perr0, ferr0}, 3'b100);
    consume(0);

    // back-to-back frames with no consumer: second is dropped
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    repeat (CPB0) @(negedge clk);
    check("t5_data",  data0, 8'h11);
    check("t5_ovr",   ovr0, 1'b1);
    check("t5_avail", avail0, 1'b1);
    consume(0);
    check("t5_ovr_clr", ovr0, 1'b0);
    check("t5_taken",   avail0, 1'b0);

    // reset in the middle of data bit 4, with a frame still held
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t6_held", avail0, 1'b1);
    pat = 8'hF0;
    drive_bit(0, 1'b0, CPB0);
    for (int i = 0; i < 4; i++) drive_bit(0, pat[i], CPB0);
    drive_bit(0, pat[4], CPB0 / 2);
    check("t6_busy_pre", busy0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_avail", avail0, 1'b0);
    check("t6_data",  data0, 8'h00);
    check("t6_busy",  busy0, 1'b0);
    check("t6_flags", {perr0, ferr0, ovr0}, 3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB0 / 2 + 4 * CPB0) @(negedge clk);
    check("t6_quiet", {avail0, busy0}, 2'b00);
    send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t6_rx_data",  data0, 8'hF0);
    check("t6_rx_flags", {avail0, perr0, ferr0, ovr0}, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
